piso_serializer: RTL

//  Parallel-in/serial-out stage feeding the catalog serial-in shift register (sll).

---
 rtl/piso_serializer_pkg.sv | 15 +
 rtl/bit_period_counter.sv | 41 ++++
 rtl/piso_serializer.sv | 94 +++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Holds the FSM state encoding and the counter-width helper.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : (($clog2(n) < 1) ? 1 : $clog2(n));
    endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Counts clocks within one serial bit period (0..DIV-1), advancing only when told to.
// Combinational ticks flag the first and last clock of the period.
module bit_period_counter
    import ser_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic adv_i,
    output logic tick_first_o,
    output logic tick_last_o
);

    localparam int DW = cnt_w(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr_i) begin
            div_cnt_d = '0;
        end else if (adv_i) begin
            div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick_first_o = (div_cnt_q == '0);
    assign tick_last_o  = (div_cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Takes a WIDTH-bit word on valid/ready and shifts it out LSB-first, DIV clocks per bit,
// with a one-cycle ser_en strobe per bit; stall freezes the bit timing without losing data.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             stall_i,
    output logic             ser_d_o,
    output logic             ser_en_o,
    output logic             busy_o,
    output logic             word_done_o
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;

    logic tick_first, tick_last;
    logic in_shift, advance, last_bit, last, accept;

    assign in_shift = (state_q == SHIFT);
    assign advance  = in_shift && !stall_i;
    assign last_bit = (bit_cnt_q == BIT_LAST);
    assign last     = advance && last_bit && tick_last;
    assign accept   = in_valid_i && in_ready_o;

    bit_period_counter #(.DIV(DIV)) u_div (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (accept),
        .adv_i        (advance),
        .tick_first_o (tick_first),
        .tick_last_o  (tick_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = SHIFT;
            SHIFT:   if (last && !in_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = !in_shift || last;
        ser_en_o    = advance && tick_first;
        ser_d_o     = shreg_q[0];
        busy_o      = in_shift;
        word_done_o = ser_en_o && last_bit;
    end

    // A word loaded at the last bit replaces the shift, so the next strobe has no gap.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shreg_d   = in_data_i;
            bit_cnt_d = '0;
        end else if (advance && tick_last) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule
